// File: rtl/sdm_mash.sv
// MASH 1-1-1 sigma-delta modulator for the fractional-N divider path.
// Up to three cascaded first-order accumulators with noise-cancelling
// differentiators, optional LFSR LSB dither, clock-enable and a clamped
// integer-plus-fraction divider output. All outputs are registered.
module sdm_mash #(
   parameter int          W         = 16,
   parameter int          NI        = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [1:0]           order,
   input  logic                 dither_en,
   input  logic [W-1:0]         din,
   input  logic [NI-1:0]        nint,
   output logic signed [3:0]    sdm_out,
   output logic [NI-1:0]        div_out,
   output logic [2:0]           carry,
   output logic                 out_valid
);

   // Saturate the widened divider sum into the unsigned NI-bit range.
   function automatic logic [NI-1:0] clamp_div(input logic signed [NI+1:0] v);
      logic signed [NI+1:0] max_v;
      max_v = $signed({2'b00, {NI{1'b1}}});
      if (v < 0)
         return '0;
      else if (v > max_v)
         return '1;
      else
         return v[NI-1:0];
   endfunction

   // Accumulator, history and dither state.
   logic [W-1:0]          r_acc1;
   logic [W-1:0]          r_acc2;
   logic [W-1:0]          r_acc3;
   logic                  r_c2_d1;
   logic                  r_c3_d1;
   logic                  r_c3_d2;
   logic [15:0]           r_lfsr;

   // Combinational chain within one cycle.
   logic                  w_en2;
   logic                  w_en3;
   logic                  w_d;
   logic [W:0]            w_in1;
   logic [W:0]            w_s1;
   logic [W:0]            w_s2;
   logic [W:0]            w_s3;
   logic                  w_c1;
   logic                  w_c2;
   logic                  w_c3;
   logic signed [3:0]     w_t1;
   logic signed [3:0]     w_t2;
   logic signed [3:0]     w_t3;
   logic signed [3:0]     w_y;
   logic signed [NI+1:0]  w_div_sum;
   logic                  w_lfsr_fb;

   // Order 0 and 1 both run stage 1 only; bit 1 enables stage 2, both bits stage 3.
   assign w_en2 = order[1];
   assign w_en3 = &order;

   // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_d       = dither_en & r_lfsr[0];

   // din + d is formed in W+1 bits so a full-scale din with dither forces c1.
   assign w_in1 = {1'b0, din} + (W+1)'(w_d);
   assign w_s1  = {1'b0, r_acc1} + w_in1;
   assign w_s2  = {1'b0, r_acc2} + {1'b0, w_s1[W-1:0]};
   assign w_s3  = {1'b0, r_acc3} + {1'b0, w_s2[W-1:0]};

   assign w_c1 = w_s1[W];
   assign w_c2 = w_en2 & w_s2[W];
   assign w_c3 = w_en3 & w_s3[W];

   // Noise-cancelling combination; terms of inactive stages are dropped so
   // stale history does not leak through on the edge an order is lowered.
   always_comb begin
      w_t1 = {3'b000, w_c1};
      w_t2 = {3'b000, w_c2} - {3'b000, r_c2_d1};
      w_t3 = {3'b000, w_c3} - {2'b00, r_c3_d1, 1'b0} + {3'b000, r_c3_d2};
      w_y  = w_t1;
      if (w_en2)
         w_y = w_y + w_t2;
      if (w_en3)
         w_y = w_y + w_t3;
   end

   assign w_div_sum = $signed({2'b00, nint}) + $signed({{(NI-2){w_y[3]}}, w_y});

   // Modulator state: advances only on enabled cycles; inactive stages held at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc1  <= '0;
         r_acc2  <= '0;
         r_acc3  <= '0;
         r_c2_d1 <= 1'b0;
         r_c3_d1 <= 1'b0;
         r_c3_d2 <= 1'b0;
         r_lfsr  <= LFSR_SEED;
      end else if (en) begin
         r_acc1  <= w_s1[W-1:0];
         r_acc2  <= w_en2 ? w_s2[W-1:0] : '0;
         r_acc3  <= w_en3 ? w_s3[W-1:0] : '0;
         r_c2_d1 <= w_c2;
         r_c3_d1 <= w_c3;
         r_c3_d2 <= w_en3 ? r_c3_d1 : 1'b0;
         if (dither_en)
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   // Output registers: data hold while disabled, valid follows en by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdm_out   <= '0;
         div_out   <= '0;
         carry     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= en;
         if (en) begin
            sdm_out <= w_y;
            div_out <= clamp_div(w_div_sum);
            carry   <= {w_c3, w_c2, w_c1};
         end
      end
   end

endmodule

// File: tb/tb_sdm_mash.sv
// Self-checking bench for sdm_mash: a behavioural model pushes expected
// outputs into a scoreboard queue on every enabled edge; they are popped
// and compared when out_valid reports them.
module tb_sdm_mash;
   localparam int W  = 16;
   localparam int NI = 8;
   localparam int FS = 1 << W;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [1:0]        order;
   logic              dither_en;
   logic [W-1:0]      din;
   logic [NI-1:0]     nint;
   logic signed [3:0] sdm_out;
   logic [NI-1:0]     div_out;
   logic [2:0]        carry;
   logic              out_valid;

   sdm_mash #(.W(W), .NI(NI), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .en(en), .order(order), .dither_en(dither_en),
      .din(din), .nint(nint), .sdm_out(sdm_out), .div_out(div_out),
      .carry(carry), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int dv;
      int c;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;

   int          m_acc1, m_acc2, m_acc3;
   int          m_c2d1, m_c3d1, m_c3d2;
   logic [15:0] m_lfsr;
   bit          m_vld;
   int          m_last_y, m_last_dv, m_last_c;
   int          sum_y;
   int          n_range_bad;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
      m_c2d1 = 0; m_c3d1 = 0; m_c3d2 = 0;
      m_lfsr = 16'hACE1;
      m_vld = 1'b0;
      m_last_y = 0; m_last_dv = 0; m_last_c = 0;
      sb.delete();
   endtask

   // One clock: update the model with the inputs the DUT will sample, then check.
   task automatic tick();
      int   ord, d, s1, s2, s3, c1, c2, c3, a1, a2, a3, y, t;
      exp_t e;
      if (en) begin
         ord = (order == 2'd0) ? 1 : int'(order);
         d   = (dither_en && m_lfsr[0]) ? 1 : 0;
         s1  = m_acc1 + int'(din) + d;
         c1  = s1 / FS;  a1 = s1 % FS;
         c2 = 0; a2 = 0; c3 = 0; a3 = 0;
         if (ord >= 2) begin
            s2 = m_acc2 + a1; c2 = s2 / FS; a2 = s2 % FS;
         end
         if (ord >= 3) begin
            s3 = m_acc3 + a2; c3 = s3 / FS; a3 = s3 % FS;
         end
         y = c1;
         if (ord >= 2) y = y + c2 - m_c2d1;
         if (ord >= 3) y = y + c3 - 2 * m_c3d1 + m_c3d2;
         t = int'(nint) + y;
         if (t < 0) t = 0;
         if (t > (1 << NI) - 1) t = (1 << NI) - 1;
         m_c3d2 = (ord >= 3) ? m_c3d1 : 0;
         m_c3d1 = c3;
         m_c2d1 = c2;
         m_acc1 = a1; m_acc2 = a2; m_acc3 = a3;
         if (dither_en)
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
         e.y = y; e.dv = t; e.c = c1 + 2 * c2 + 4 * c3;
         sb.push_back(e);
      end
      m_vld = en;
      @(posedge clk);
      #1;
      check("out_valid", int'(out_valid), int'(m_vld));
      if (out_valid) begin
         check("sb_depth", sb.size(), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sdm_out", int'(sdm_out), e.y);
            check("div_out", int'(div_out), e.dv);
            check("carry", int'(carry), e.c);
            m_last_y = e.y; m_last_dv = e.dv; m_last_c = e.c;
         end
         sum_y = sum_y + int'(sdm_out);
         if (int'(sdm_out) < -3 || int'(sdm_out) > 4) n_range_bad++;
      end else begin
         check("hold_sdm", int'(sdm_out), m_last_y);
         check("hold_div", int'(div_out), m_last_dv);
         check("hold_carry", int'(carry), m_last_c);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("rst_sdm", int'(sdm_out), 0);
      check("rst_div", int'(div_out), 0);
      check("rst_carry", int'(carry), 0);
      check("rst_vld", int'(out_valid), 0);
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int neg_seen, pos_seen;
      rst = 1'b1; en = 1'b0; order = 2'd1; dither_en = 1'b0; din = '0; nint = '0;
      sum_y = 0; n_range_bad = 0;
      do_reset();

      // Idle input at full order: nothing may toggle.
      order = 2'd3; din = '0; nint = 8'd37; en = 1'b1;
      repeat (100) begin
         tick();
         check("t1_sdm", int'(sdm_out), 0);
         check("t1_carry", int'(carry), 0);
         check("t1_div", int'(div_out), 37);
      end

      // Half-scale first order: alternating 0,1.
      en = 1'b0;
      do_reset();
      order = 2'd1; din = 16'h8000; nint = 8'd10; en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t2_alt", int'(sdm_out), i % 2);
      end

      // Third order mean and range.
      en = 1'b0;
      do_reset();
      order = 2'd3; din = 16'h4000; nint = 8'd50; en = 1'b1;
      sum_y = 0; n_range_bad = 0;
      repeat (4096) tick();
      check("t3_sum_window", int'(sum_y >= 1020 && sum_y <= 1028), 1);
      check("t3_range_viol", n_range_bad, 0);

      // Clamp at both ends with second order.
      en = 1'b0;
      do_reset();
      order = 2'd2; din = 16'h0100; nint = 8'd0; en = 1'b1;
      neg_seen = 0;
      repeat (600) begin
         tick();
         if (m_last_y < 0) begin
            neg_seen++;
            check("t4_clamp_lo", int'(div_out), 0);
         end
      end
      check("t4_neg_seen", int'(neg_seen > 0), 1);
      nint = 8'd255;
      pos_seen = 0;
      repeat (600) begin
         tick();
         if (m_last_y > 0) begin
            pos_seen++;
            check("t4_clamp_hi", int'(div_out), 255);
         end
      end
      check("t4_pos_seen", int'(pos_seen > 0), 1);

      // Pause with dither and order 3; model continues as an unpaused run.
      en = 1'b0;
      do_reset();
      order = 2'd3; din = 16'h3A7B; nint = 8'd100; dither_en = 1'b1; en = 1'b1;
      repeat (50) tick();
      en = 1'b0;
      repeat (10) begin
         tick();
         check("t5_paused_vld", int'(out_valid), 0);
      end
      en = 1'b1;
      repeat (50) tick();

      // Full-scale input with dither forces c1 on dithered cycles.
      en = 1'b0;
      do_reset();
      order = 2'd1; din = 16'hFFFF; nint = 8'd3; dither_en = 1'b1; en = 1'b1;
      repeat (40) tick();

      // Long dithered zero-input run, then asynchronous reset mid-run.
      en = 1'b0;
      do_reset();
      order = 2'd1; din = '0; nint = 8'd20; dither_en = 1'b1; en = 1'b1;
      sum_y = 0;
      repeat (65535) tick();
      check("t6_sum_0_or_1", int'(sum_y == 0 || sum_y == 1), 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_arst_sdm", int'(sdm_out), 0);
      check("t6_arst_div", int'(div_out), 0);
      check("t6_arst_carry", int'(carry), 0);
      check("t6_arst_vld", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      order = 2'd1; din = 16'h8000; dither_en = 1'b0; nint = 8'd7;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t6_post_rst_alt", int'(sdm_out), i % 2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
